// File: rtl/bcd2bin_conv.sv
// rtl/bcd2bin_conv.sv - two-digit packed BCD to 7-bit binary converter (reverse double-dabble)
module bcd2bin_conv #(
  parameter logic [6:0] ERR_VALUE = 7'h7F
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] bcd_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Work register layout: [14:11] tens digit, [10:7] ones digit, [6:0] binary
  // bits collected as the digits are shifted right.
  localparam logic [2:0] LAST_SHIFT = 3'd6;

  state_t      state, state_nx;
  logic [14:0] work, work_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        busy_nx, done_nx, err_nx;
  logic [6:0]  result_nx;

  logic [14:0] shifted;
  logic [14:0] corrected;
  logic        bad_digit;

  // One reverse double-dabble step: shift right, then pull any digit field
  // that reached 8 or more back down by 3 so it stays a valid BCD digit.
  always_comb begin
    shifted   = {1'b0, work[14:1]};
    corrected = shifted;
    if (shifted[14:11] >= 4'd8) begin
      corrected[14:11] = shifted[14:11] - 4'd3;
    end
    if (shifted[10:7] >= 4'd8) begin
      corrected[10:7] = shifted[10:7] - 4'd3;
    end
  end

  assign bad_digit = (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);

  // State, datapath and registered outputs; reset discards any conversion in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nx;
      work   <= work_nx;
      cnt    <= cnt_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      err    <= err_nx;
      result <= result_nx;
    end
  end

  // Next-state and next-output decode; result/err hold unless a conversion completes.
  always_comb begin
    state_nx  = state;
    work_nx   = work;
    cnt_nx    = cnt;
    busy_nx   = busy;
    done_nx   = 1'b0;
    err_nx    = err;
    result_nx = result;

    case (state)
      IDLE, DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
        if (start) begin
          if (bad_digit) begin
            state_nx  = DONE;
            err_nx    = 1'b1;
            result_nx = ERR_VALUE;
            done_nx   = 1'b1;
          end else begin
            work_nx  = {bcd_in, 7'b0};
            cnt_nx   = '0;
            err_nx   = 1'b0;
            busy_nx  = 1'b1;
            state_nx = SHIFT;
          end
        end
      end

      SHIFT: begin
        work_nx = corrected;
        cnt_nx  = cnt + 3'd1;
        if (cnt == LAST_SHIFT) begin
          result_nx = corrected[6:0];
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
          state_nx  = DONE;
        end
      end

      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/bcd2bin_conv.md
Name: bcd2bin_conv

Overview:
- Sequential converter from two packed BCD digits (tens, ones) to a 7-bit unsigned binary value, 0..99.
- It is the inverse of the binary-to-BCD/7-segment display path. It turns operator-entered decimal digits from switches back into the binary operand used by the datapath.
- Conversion is iterative reverse double-dabble: one shift per clock, with a start/busy/done handshake.

Parameters:
- ERR_VALUE, 7'h7F, value driven on result when an input digit is not valid BCD.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request a conversion. Sampled only in IDLE or DONE.
- bcd_in  input  8  packed BCD: [7:4] tens digit, [3:0] ones digit. Captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse: result/err valid.
- err  output  1  digit > 9 detected on the accepted input.
- result  output  7  binary value. Held until the next accepted start.

Behaviour:
- Reset: synchronous. On a clock edge with reset_n=0:
  - state=IDLE.
  - busy=0, done=0, err=0, result=0.
  - Internal shift register and counter cleared.
  - This applies in any state, including mid-SHIFT. A conversion in progress is discarded and no done is issued.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE, start=1 at edge E:
  - If tens>9 or ones>9: state->DONE; err=1; result=ERR_VALUE. done=1 is visible after edge E, so the error latency is 1 edge.
  - Otherwise: load work register W = {tens, ones, 7'b0} (15 bits); cnt=0; err=0; state->SHIFT; busy=1.
- SHIFT, each edge:
  - W = W >> 1 (zero fill at MSB).
  - Then, for each 4-bit digit field of the shifted W: if the field >= 8, subtract 3.
  - cnt increments.
  - On the 7th shift (cnt==6 before the edge): result = W[6:0] after the shift; state->DONE; busy=0; done=1.
- Latency: start accepted at edge E gives done=1 after edge E+7. The digit remainders are zero at completion for all valid inputs.
- DONE: lasts exactly one cycle; done=1.
  - At the next edge, done->0.
  - If start=1 at that edge, it is accepted exactly as in IDLE (back-to-back conversion, with done then low for the SHIFT cycles).
  - Otherwise state->IDLE.
- start while in SHIFT: ignored. No restart, no effect on the in-flight conversion.
- bcd_in is sampled only at the accepting edge. Changes during SHIFT have no effect.
- result and err:
  - Hold their values through IDLE and SHIFT until the next completion (DONE entry) overwrites them.
  - err is cleared on acceptance of a valid request.
- Width rules:
  - Max valid result is 99, which fits in 7 bits. No overflow is possible.
  - Digit correction is 4-bit, unsigned.
  - Correction applies after every shift, including the last.

Test Plan:
- Reset, then bcd_in=8'h22 with a 1-cycle start -> busy high for 7 cycles; done pulses 7 edges after acceptance; result=7'd22; err=0.
- bcd_in=8'h99 -> result=7'd99. bcd_in=8'h00 -> result=0. bcd_in=8'h58 -> result=7'd58. done is exactly one cycle wide in each case.
- bcd_in=8'hA6 (tens invalid) and 8'h3F (ones invalid) -> done 1 edge after start; err=1; result=7'h7F; busy never asserted.
- Start 8'h58, then pulse start with bcd_in=8'h07 during SHIFT -> second start ignored; result=7'd58. Then hold start high with 8'h07 in DONE -> back-to-back accept; result=7'd7 seven edges later.
- Start 8'h99; drive reset_n=0 for one edge at the 3rd SHIFT cycle -> all outputs 0, state IDLE, no done pulse. A subsequent 8'h13 conversion gives result=7'd13.
- Exhaustive sweep of all 100 valid BCD inputs, each checked against tens*10+ones; err=0 throughout.
